icache: RTL and testbench

ICACHE -- requirements
Module: icache

---
 rtl/icache_pkg.sv | 29 ++
 rtl/icache_array.sv | 51 +++++
 rtl/icache.sv | 110 +++++++++++
 tb/tb_icache.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared constants for the instruction cache: FSM state encodings and
// helpers that derive the address-field widths from the cache geometry.
// Address split from the LSB: byte[1:0] | word offset | index | tag.
package icache_pkg;

   localparam int BYTE_BITS = 2;
   localparam int WORD_W    = 32;

   // FSM state encodings
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_FILL = 2'd2;

   // Word-offset width for a line of line_words 32-bit words.
   function automatic int off_w(input int line_words);
      return $clog2(line_words);
   endfunction

   // Index width for n_lines direct-mapped lines.
   function automatic int idx_w(input int n_lines);
      return $clog2(n_lines);
   endfunction

   // Tag width: whatever is left above byte, offset and index bits.
   function automatic int tag_w(input int addr_w, input int n_lines, input int line_words);
      return addr_w - BYTE_BITS - $clog2(line_words) - $clog2(n_lines);
   endfunction

endpackage

// File: rtl/icache_array.sv
// Tag/valid/data storage for the direct-mapped instruction cache.
// One asynchronous read port (indexed by the fetch pc) and one synchronous
// write port (line fill). Only the valid bits are reset.
//   clk, reset        : clock, synchronous active-high reset (clears valid)
//   rd_idx            : read line index
//   rd_valid/tag/data : contents of the indexed line
//   wr_en/idx/tag/data: fill a whole line and mark it valid
module icache_array
   import icache_pkg::*;
#(
   parameter int N_LINES    = 4,
   parameter int LINE_WORDS = 4,
   parameter int TAG_W      = 26,
   parameter int IDX_W      = $clog2(N_LINES)
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [IDX_W-1:0]           rd_idx,
   output logic                       rd_valid,
   output logic [TAG_W-1:0]           rd_tag,
   output logic [WORD_W*LINE_WORDS-1:0] rd_data,
   input  logic                       wr_en,
   input  logic [IDX_W-1:0]           wr_idx,
   input  logic [TAG_W-1:0]           wr_tag,
   input  logic [WORD_W*LINE_WORDS-1:0] wr_data
);

   logic [N_LINES-1:0]              valid_q;
   logic [TAG_W-1:0]                tag_q  [N_LINES];
   logic [WORD_W*LINE_WORDS-1:0]    data_q [N_LINES];

   always_ff @(posedge clk) begin
      if (reset)
         valid_q <= '0;
      else if (wr_en)
         valid_q[wr_idx] <= 1'b1;
   end

   // Tag and data need no reset: valid gates every use of them.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         tag_q[wr_idx]  <= wr_tag;
         data_q[wr_idx] <= wr_data;
      end
   end

   assign rd_valid = valid_q[rd_idx];
   assign rd_tag   = tag_q[rd_idx];
   assign rd_data  = data_q[rd_idx];

endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache with a blocking single-line refill.
// Hits in IDLE are served combinationally; a miss walks IDLE -> REQ -> FILL
// and the pc is looked up again on return to IDLE.
//   clk, reset   : clock, synchronous active-high reset
//   pc           : fetch address (bits [1:0] ignored)
//   instruction  : fetched word, 0 while stalled
//   stall        : pc not served this cycle
//   mem_req/addr : line-fill request and line-aligned address
//   mem_ack/data : fill-data pulse and the full line (word 0 in LSBs)
//   miss_count   : completed fills, wraps at 2^16
module icache
   import icache_pkg::*;
#(
   parameter int ADDRESS_SIZE = 32,
   parameter int N_LINES      = 4,
   parameter int LINE_WORDS   = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [ADDRESS_SIZE-1:0]      pc,
   output logic [31:0]                  instruction,
   output logic                         stall,
   output logic                         mem_req,
   output logic [ADDRESS_SIZE-1:0]      mem_addr,
   input  logic                         mem_ack,
   input  logic [WORD_W*LINE_WORDS-1:0] mem_data,
   output logic [15:0]                  miss_count
);

   localparam int OFF_W  = off_w(LINE_WORDS);
   localparam int IDX_W  = idx_w(N_LINES);
   localparam int TAG_W  = tag_w(ADDRESS_SIZE, N_LINES, LINE_WORDS);
   localparam int LOW_W  = BYTE_BITS + OFF_W;   // bits below the index

   logic [1:0]              state_q;
   logic [ADDRESS_SIZE-1:0] miss_addr_q;
   logic [15:0]             miss_count_q;

   logic [OFF_W-1:0]        pc_off;
   logic [IDX_W-1:0]        pc_idx;
   logic [TAG_W-1:0]        pc_tag;
   logic                    rd_valid;
   logic [TAG_W-1:0]        rd_tag;
   logic [WORD_W*LINE_WORDS-1:0] rd_data;
   logic [LINE_WORDS-1:0][WORD_W-1:0] rd_words;
   logic                    tag_hit;
   logic                    hit;
   logic                    wr_en;
   logic                    unused_pc_bits;

   assign pc_off = pc[BYTE_BITS +: OFF_W];
   assign pc_idx = pc[LOW_W +: IDX_W];
   assign pc_tag = pc[ADDRESS_SIZE-1 -: TAG_W];
   assign unused_pc_bits = ^pc[BYTE_BITS-1:0];

   // Fill uses only miss_addr, so a pc change during REQ/FILL cannot
   // redirect the line being written.
   assign wr_en = !reset && (state_q == ST_REQ) && mem_ack;

   icache_array #(
      .N_LINES    (N_LINES),
      .LINE_WORDS (LINE_WORDS),
      .TAG_W      (TAG_W),
      .IDX_W      (IDX_W)
   ) u_array (
      .clk      (clk),
      .reset    (reset),
      .rd_idx   (pc_idx),
      .rd_valid (rd_valid),
      .rd_tag   (rd_tag),
      .rd_data  (rd_data),
      .wr_en    (wr_en),
      .wr_idx   (miss_addr_q[LOW_W +: IDX_W]),
      .wr_tag   (miss_addr_q[ADDRESS_SIZE-1 -: TAG_W]),
      .wr_data  (mem_data)
   );

   // Output path sees only stored contents, never mem_data.
   assign rd_words = rd_data;
   assign tag_hit  = rd_valid && (rd_tag == pc_tag);
   assign hit      = !reset && (state_q == ST_IDLE) && tag_hit;

   assign stall       = !hit;
   assign instruction = hit ? rd_words[pc_off] : 32'd0;
   assign mem_req     = !reset && (state_q == ST_REQ);
   assign mem_addr    = miss_addr_q;
   assign miss_count  = miss_count_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         miss_addr_q  <= '0;
         miss_count_q <= '0;
      end else begin
         case (state_q)
            ST_IDLE: if (!tag_hit) begin
               miss_addr_q <= {pc[ADDRESS_SIZE-1:LOW_W], {LOW_W{1'b0}}};
               state_q     <= ST_REQ;
            end
            ST_REQ: if (mem_ack) begin
               miss_count_q <= miss_count_q + 16'd1;
               state_q      <= ST_FILL;
            end
            ST_FILL: state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_icache.sv
module tb_icache;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [31:0]  pc = '0;
   logic [31:0]  instruction;
   logic         stall;
   logic         mem_req;
   logic [31:0]  mem_addr;
   logic         mem_ack = 1'b0;
   logic [127:0] mem_data = '0;
   logic [15:0]  miss_count;

   int errors = 0;
   int checks = 0;

   icache dut (
      .clk         (clk),
      .reset       (reset),
      .pc          (pc),
      .instruction (instruction),
      .stall       (stall),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_ack     (mem_ack),
      .mem_data    (mem_data),
      .miss_count  (miss_count)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   // Memory contents: each word is its own address XOR a marker.
   function automatic logic [31:0] w(input logic [31:0] a);
      return {a[31:2], 2'b00} ^ 32'h5A5A_0000;
   endfunction

   function automatic logic [127:0] line_of(input logic [31:0] base);
      logic [127:0] l;
      for (int i = 0; i < 4; i++) l[i*32 +: 32] = w(base + 32'(4*i));
      return l;
   endfunction

   typedef struct {
      logic        rst;
      logic [31:0] pc;
      logic        ack;
      logic [31:0] fill;
      logic        e_stall;
      logic [31:0] e_ins;
      logic        e_req;
      logic [31:0] e_addr;
      logic [15:0] e_cnt;
   } vec_t;

   function automatic vec_t mk(input logic rst, input logic [31:0] p, input logic ack,
                               input logic [31:0] fill, input logic st, input logic [31:0] ins,
                               input logic rq, input logic [31:0] ad, input logic [15:0] cnt);
      vec_t v;
      v.rst = rst; v.pc = p; v.ack = ack; v.fill = fill;
      v.e_stall = st; v.e_ins = ins; v.e_req = rq; v.e_addr = ad; v.e_cnt = cnt;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   // One cycle: drive on the falling edge, settle, outputs then valid.
   task automatic drive(input logic r, input logic [31:0] p, input logic a, input logic [31:0] fill);
      @(negedge clk);
      reset = r; pc = p; mem_ack = a; mem_data = line_of(fill);
      #1;
   endtask

   vec_t vecs[22];

   initial begin
      // reset (ack during reset must be ignored)
      vecs[0]  = mk(1, 32'h0,    0, 32'h0,    1, 32'h0,        0, 32'h0,    0);
      vecs[1]  = mk(1, 32'h1000, 1, 32'h1000, 1, 32'h0,        0, 32'h0,    0);
      // miss on 1000, ack on the third mem_req cycle: 5 stall cycles
      vecs[2]  = mk(0, 32'h1000, 0, 32'h0,    1, 32'h0,        0, 32'h0,    0);
      vecs[3]  = mk(0, 32'h1000, 0, 32'h0,    1, 32'h0,        1, 32'h1000, 0);
      vecs[4]  = mk(0, 32'h1000, 0, 32'h0,    1, 32'h0,        1, 32'h1000, 0);
      vecs[5]  = mk(0, 32'h1000, 1, 32'h1000, 1, 32'h0,        1, 32'h1000, 0);
      vecs[6]  = mk(0, 32'h1000, 0, 32'h0,    1, 32'h0,        0, 32'h1000, 1);
      vecs[7]  = mk(0, 32'h1000, 0, 32'h0,    0, w(32'h1000),  0, 32'h1000, 1);
      // streaming hits over the same line
      vecs[8]  = mk(0, 32'h1004, 0, 32'h0,    0, w(32'h1004),  0, 32'h1000, 1);
      vecs[9]  = mk(0, 32'h1008, 0, 32'h0,    0, w(32'h1008),  0, 32'h1000, 1);
      vecs[10] = mk(0, 32'h100C, 0, 32'h0,    0, w(32'h100C),  0, 32'h1000, 1);
      // stray ack in IDLE while hitting
      vecs[11] = mk(0, 32'h1004, 1, 32'h2000, 0, w(32'h1004),  0, 32'h1000, 1);
      vecs[12] = mk(0, 32'h1004, 0, 32'h0,    0, w(32'h1004),  0, 32'h1000, 1);
      // conflict: 1040 evicts 1000, then 1000 evicts 1040
      vecs[13] = mk(0, 32'h1040, 0, 32'h0,    1, 32'h0,        0, 32'h1000, 1);
      vecs[14] = mk(0, 32'h1040, 1, 32'h1040, 1, 32'h0,        1, 32'h1040, 1);
      vecs[15] = mk(0, 32'h1040, 0, 32'h0,    1, 32'h0,        0, 32'h1040, 2);
      vecs[16] = mk(0, 32'h1040, 0, 32'h0,    0, w(32'h1040),  0, 32'h1040, 2);
      vecs[17] = mk(0, 32'h1000, 0, 32'h0,    1, 32'h0,        0, 32'h1040, 2);
      vecs[18] = mk(0, 32'h1000, 1, 32'h1000, 1, 32'h0,        1, 32'h1000, 2);
      vecs[19] = mk(0, 32'h1000, 0, 32'h0,    1, 32'h0,        0, 32'h1000, 3);
      vecs[20] = mk(0, 32'h1000, 0, 32'h0,    0, w(32'h1000),  0, 32'h1000, 3);
      // byte bits ignored
      vecs[21] = mk(0, 32'h100F, 0, 32'h0,    0, w(32'h100C),  0, 32'h1000, 3);

      for (int i = 0; i < 22; i++) begin
         drive(vecs[i].rst, vecs[i].pc, vecs[i].ack, vecs[i].fill);
         chk($sformatf("v%0d stall", i),   {31'd0, stall},      {31'd0, vecs[i].e_stall});
         chk($sformatf("v%0d instr", i),   instruction,         vecs[i].e_ins);
         chk($sformatf("v%0d mem_req", i), {31'd0, mem_req},    {31'd0, vecs[i].e_req});
         if (vecs[i].e_req)
            chk($sformatf("v%0d mem_addr", i), mem_addr,        vecs[i].e_addr);
         chk($sformatf("v%0d count", i),   {16'd0, miss_count}, {16'd0, vecs[i].e_cnt});
      end

      // pc moves to 2000 during REQ for 1000: fill stays on 1000, then refetch 2000
      begin
         bit found = 0;
         drive(1, 32'h0, 0, 32'h0);
         drive(0, 32'h1000, 0, 32'h0);
         drive(0, 32'h1000, 0, 32'h0);
         chk("redir req_addr", mem_addr, 32'h1000);
         drive(0, 32'h2000, 0, 32'h0);
         chk("redir req_held", {31'd0, mem_req}, 32'd1);
         chk("redir addr_held", mem_addr, 32'h1000);
         drive(0, 32'h2000, 1, 32'h1000);
         chk("redir addr_ack", mem_addr, 32'h1000);
         drive(0, 32'h2000, 0, 32'h0);
         chk("redir fill_stall", {31'd0, stall}, 32'd1);
         chk("redir fill_req", {31'd0, mem_req}, 32'd0);
         chk("redir fill_cnt", {16'd0, miss_count}, 32'd1);
         drive(0, 32'h2000, 0, 32'h0);
         chk("redir idle_miss", {31'd0, stall}, 32'd1);
         for (int n = 0; n < 6 && !found; n++) begin
            drive(0, 32'h2000, 0, 32'h0);
            if (mem_req) found = 1;
         end
         chk("redir second_req", {31'd0, found}, 32'd1);
         chk("redir second_addr", mem_addr, 32'h2000);
         drive(0, 32'h2000, 1, 32'h2000);
         drive(0, 32'h2000, 0, 32'h0);
         drive(0, 32'h2000, 0, 32'h0);
         chk("redir hit_stall", {31'd0, stall}, 32'd0);
         chk("redir hit_instr", instruction, w(32'h2000));
         chk("redir hit_cnt", {16'd0, miss_count}, 32'd2);
      end

      // reset during REQ with ack in the same cycle abandons the fill
      drive(1, 32'h0, 0, 32'h0);
      drive(0, 32'h1000, 0, 32'h0);
      drive(0, 32'h1000, 0, 32'h0);
      chk("rstreq req", {31'd0, mem_req}, 32'd1);
      drive(1, 32'h1000, 1, 32'h1000);
      chk("rstreq req_off", {31'd0, mem_req}, 32'd0);
      chk("rstreq stall", {31'd0, stall}, 32'd1);
      chk("rstreq instr", instruction, 32'h0);
      drive(0, 32'h1000, 0, 32'h0);
      chk("rstreq miss", {31'd0, stall}, 32'd1);
      chk("rstreq cnt0", {16'd0, miss_count}, 32'd0);
      drive(0, 32'h1000, 0, 32'h0);
      chk("rstreq req2", {31'd0, mem_req}, 32'd1);
      chk("rstreq cnt_req", {16'd0, miss_count}, 32'd0);
      drive(0, 32'h1000, 1, 32'h1000);
      drive(0, 32'h1000, 0, 32'h0);
      chk("rstreq cnt1", {16'd0, miss_count}, 32'd1);
      drive(0, 32'h1000, 0, 32'h0);
      chk("rstreq hit", {31'd0, stall}, 32'd0);
      chk("rstreq instr2", instruction, w(32'h1000));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
